// File: rtl/decoder_pkg.sv
// Shared constants, scan-state encoding and one-hot helper for decoder_scan_n.
// Used by the RTL and by the testbench.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest select the helper supports; callers cast the result down to N bits.
    localparam int MAX_SEL_W = 8;
    localparam int MAX_N     = 1 << MAX_SEL_W;

    typedef enum logic {
        SCAN_DWELL = 1'b0,
        SCAN_STEP  = 1'b1
    } scan_state_e;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_N-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/decoder_scan_ctr.sv
// Scan sequencer for decoder_scan_n: owns the dwell counter, active index,
// previous-mode flop and wrap pulse. Only instantiated when DECODER_SCAN_EN is defined.
module decoder_scan_ctr
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [SEL_W-1:0]   o_idx_next,
    output logic [SEL_W-1:0]   o_idx,
    output logic               o_wrap
);

    localparam logic [SEL_W-1:0] IDX_MAX = {SEL_W{1'b1}};

    logic [DWELL_W-1:0] r_cnt;
    logic [SEL_W-1:0]   r_idx;
    logic               r_prev_mode;
    logic               r_wrap;

    scan_state_e        w_state;
    logic [DWELL_W-1:0] w_cnt_next;
    logic [SEL_W-1:0]   w_idx_next;
    logic               w_prev_next;
    logic               w_wrap_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_prev_mode <= MODE_DIRECT;
            r_wrap      <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_idx       <= w_idx_next;
            r_prev_mode <= w_prev_next;
            r_wrap      <= w_wrap_next;
        end
    end

    // >= rather than == so a dwell lowered below the running count steps at once.
    always_comb begin
        w_state     = (r_cnt >= i_dwell) ? SCAN_STEP : SCAN_DWELL;
        w_cnt_next  = r_cnt;
        w_idx_next  = r_idx;
        w_prev_next = r_prev_mode;
        w_wrap_next = 1'b0;
        if (i_en) begin
            w_prev_next = i_mode;
            if (i_mode == MODE_DIRECT) begin
                w_idx_next = i_sel;
                w_cnt_next = '0;
            end else if (r_prev_mode == MODE_DIRECT) begin
                w_idx_next = '0;
                w_cnt_next = '0;
            end else if (w_state == SCAN_STEP) begin
                w_cnt_next  = '0;
                w_idx_next  = r_idx + 1'b1;
                w_wrap_next = (r_idx == IDX_MAX);
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    assign o_idx_next = w_idx_next;
    assign o_idx      = r_idx;
    assign o_wrap     = r_wrap;

endmodule

// File: rtl/decoder_scan_n.sv
// Registered binary-to-one-hot decoder with enable and optional scan mode.
// Scan mode, dwell counter and wrap exist only when DECODER_SCAN_EN is defined.
module decoder_scan_n
    import decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(1<<SEL_W)-1:0] y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap,
    output logic                  active
);

    localparam int N = 1 << SEL_W;

    logic [N-1:0]     r_y;
    logic             r_active;
    logic [SEL_W-1:0] w_idx_next;
    logic [SEL_W-1:0] w_idx;
    logic             w_wrap;
    logic [N-1:0]     w_y_next;

`ifdef DECODER_SCAN_EN
    decoder_scan_ctr #(
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W)
    ) u_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_mode     (mode),
        .i_sel      (sel),
        .i_dwell    (dwell),
        .o_idx_next (w_idx_next),
        .o_idx      (w_idx),
        .o_wrap     (w_wrap)
    );
`else
    // Direct-only build: mode and dwell are deliberately ignored.
    logic [SEL_W-1:0] r_idx;
    logic             w_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else begin
            r_idx <= w_idx_next;
        end
    end

    assign w_idx_next = en ? sel : r_idx;
    assign w_idx      = r_idx;
    assign w_wrap     = 1'b0;
    assign w_unused   = ^{mode, dwell};
`endif

    assign w_y_next = N'(onehot(MAX_SEL_W'(w_idx_next)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y      <= '0;
            r_active <= 1'b0;
        end else if (!en) begin
            r_y      <= '0;
            r_active <= 1'b0;
        end else begin
            r_y      <= w_y_next;
            r_active <= 1'b1;
        end
    end

    assign y      = r_y;
    assign idx    = w_idx;
    assign wrap   = w_wrap;
    assign active = r_active;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed table-driven bench for decoder_scan_n (default width) plus a SEL_W=3 instance.
// Scan expectations apply when DECODER_SCAN_EN is defined; otherwise mode is checked as ignored.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic [3:0] y;
    logic [1:0] idx;
    logic       wrap, active;

    logic       rst3, en3, mode3;
    logic [2:0] sel3;
    logic [3:0] dwell3;
    logic [7:0] y3;
    logic [2:0] idx3;
    logic       wrap3, active3;

    decoder_scan_n #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
        .y(y), .idx(idx), .wrap(wrap), .active(active)
    );

    decoder_scan_n #(.SEL_W(3), .DWELL_W(4)) dut3 (
        .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .sel(sel3), .dwell(dwell3),
        .y(y3), .idx(idx3), .wrap(wrap3), .active(active3)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [1:0] sel;
        logic [7:0] dwell;
        logic [3:0] ey;
        logic [1:0] eidx;
        logic       ewrap;
        logic       eact;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] ey, input logic [1:0] ei,
                                input logic ew, input logic ea);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sel = s; v.dwell = d;
        v.ey = ey; v.eidx = ei; v.ewrap = ew; v.eact = ea;
        vecs.push_back(v);
    endfunction

    task automatic check3(input string nm, input logic [7:0] ey, input logic [2:0] ei);
        logic ea;
        ea = (ey != 8'd0);
        @(posedge clk);
        #1;
        n_vec++;
        if (y3 !== ey || idx3 !== ei || active3 !== ea || wrap3 !== 1'b0) begin
            n_err++;
            $display("FAIL %s: y=%b idx=%0d active=%b wrap=%b, required y=%b idx=%0d active=%b wrap=0",
                     nm, y3, idx3, active3, wrap3, ey, ei, ea);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0; dwell = 8'd0;
        rst3 = 1'b1; en3 = 1'b0; mode3 = 1'b0; sel3 = 3'd0; dwell3 = 4'd0;

        //   rst en mode sel dwell   y        idx  wrap act
        add(1, 1, 0, 2'd3, 8'd0, 4'b0000, 2'd0, 0, 0);
        add(1, 1, 0, 2'd3, 8'd0, 4'b0000, 2'd0, 0, 0);
        add(0, 1, 0, 2'd0, 8'd0, 4'b0001, 2'd0, 0, 1);
        add(0, 1, 0, 2'd1, 8'd0, 4'b0010, 2'd1, 0, 1);
        add(0, 1, 0, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
        add(0, 1, 0, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 1);
        add(0, 0, 0, 2'd2, 8'd0, 4'b0000, 2'd3, 0, 0);
        add(0, 1, 0, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
`ifdef DECODER_SCAN_EN
        // dwell=0 sweep: entry at line 0, wrap only on the second 0001
        add(0, 1, 1, 2'd2, 8'd0, 4'b0001, 2'd0, 0, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0010, 2'd1, 0, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b1000, 2'd3, 0, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0001, 2'd0, 1, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0010, 2'd1, 0, 1);
        // dwell=2: three enabled cycles per line, 5-cycle freeze mid-step
        add(0, 1, 1, 2'd2, 8'd2, 4'b0010, 2'd1, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0010, 2'd1, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0100, 2'd2, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0100, 2'd2, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 2'd2, 8'd2, 4'b0000, 2'd2, 0, 0);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0100, 2'd2, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b1000, 2'd3, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b1000, 2'd3, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b1000, 2'd3, 0, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0001, 2'd0, 1, 1);
        add(0, 1, 1, 2'd2, 8'd2, 4'b0001, 2'd0, 0, 1);
        // exit to direct sel=3, re-enter with dwell=5, then drop dwell to 1 at cnt=4
        add(0, 1, 0, 2'd3, 8'd2, 4'b1000, 2'd3, 0, 1);
        add(0, 1, 1, 2'd2, 8'd5, 4'b0001, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++) add(0, 1, 1, 2'd2, 8'd5, 4'b0001, 2'd0, 0, 1);
        add(0, 1, 1, 2'd2, 8'd1, 4'b0010, 2'd1, 0, 1);
        // mode edge while disabled is acted on at the first enabled cycle
        add(0, 1, 0, 2'd2, 8'd1, 4'b0100, 2'd2, 0, 1);
        add(0, 0, 1, 2'd2, 8'd1, 4'b0000, 2'd2, 0, 0);
        add(0, 1, 1, 2'd2, 8'd1, 4'b0001, 2'd0, 0, 1);
        // reset mid-scan, then scan restarts from line 0 with no wrap
        add(1, 1, 1, 2'd2, 8'd0, 4'b0000, 2'd0, 0, 0);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0001, 2'd0, 0, 1);
        add(0, 1, 1, 2'd2, 8'd0, 4'b0010, 2'd1, 0, 1);
`else
        // direct-only build: mode and dwell have no effect
        add(0, 1, 1, 2'd2, 8'd0, 4'b0100, 2'd2, 0, 1);
        add(0, 1, 1, 2'd1, 8'd3, 4'b0010, 2'd1, 0, 1);
        add(0, 1, 1, 2'd1, 8'd3, 4'b0010, 2'd1, 0, 1);
        add(1, 1, 1, 2'd3, 8'd0, 4'b0000, 2'd0, 0, 0);
        add(0, 1, 1, 2'd3, 8'd0, 4'b1000, 2'd3, 0, 1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
            sel = vecs[i].sel; dwell = vecs[i].dwell;
            @(posedge clk);
            #1;
            n_vec++;
            if (y !== vecs[i].ey || idx !== vecs[i].eidx ||
                wrap !== vecs[i].ewrap || active !== vecs[i].eact) begin
                n_err++;
                $display("FAIL vec%0d: y=%b idx=%0d wrap=%b active=%b, required y=%b idx=%0d wrap=%b active=%b",
                         i, y, idx, wrap, active,
                         vecs[i].ey, vecs[i].eidx, vecs[i].ewrap, vecs[i].eact);
            end
        end

        // SEL_W=3 instance: reset priority mid-scan and exhaustive direct decode
        rst3 = 1'b1;
        check3("w3_reset", 8'd0, 3'd0);
        rst3 = 1'b0; en3 = 1'b1;
`ifdef DECODER_SCAN_EN
        mode3 = 1'b1; dwell3 = 4'd0;
        check3("w3_scan0", 8'b0000_0001, 3'd0);
        check3("w3_scan1", 8'b0000_0010, 3'd1);
        check3("w3_scan2", 8'b0000_0100, 3'd2);
        rst3 = 1'b1;
        check3("w3_rst_mid_scan", 8'd0, 3'd0);
        rst3 = 1'b0;
`endif
        mode3 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] ey;
            ey   = 8'd1 << i;
            sel3 = 3'(i);
            check3($sformatf("w3_direct%0d", i), ey, 3'(i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_scan_n.md
# decoder_scan_n

Parametrised registered binary-to-one-hot decoder, the successor to the 2-to-4 combinational decoder. It adds a registered output stage and an enable. It also adds an autonomous scan mode that steps the active output through every line with a programmable dwell time. Typical use is row/chip-select generation and display or keypad multiplexing, driven by the local controller.

## Interface
Parameters:
- SEL_W, default 2: select width; output count N = 2**SEL_W.
- DWELL_W, default 8: width of the dwell-time input.

Ports:
- clk  input  1  rising-edge clock; the only clock domain.
- rst  input  1  reset; synchronous and active-high.
- en  input  1  enable; 0 forces y to all-zero and freezes scan state.
- mode  input  1  0 = direct decode, 1 = scan.
- sel  input  SEL_W  line select, used in direct mode.
- dwell  input  DWELL_W  extra cycles per scan step; a step lasts dwell+1 cycles.
- y  output  N  one-hot (or all-zero) registered output.
- idx  output  SEL_W  index of the currently active line.
- wrap  output  1  one-cycle pulse when scan steps from N-1 to 0.
- active  output  1  high when y is non-zero.

## Operation
- Reset values (rst=1 at a clock edge):
  - y=0, idx=0, wrap=0, active=0.
  - Internal dwell counter cnt=0.
  - Previous-mode register = direct.
- Direct mode (mode=0, en=1):
  - y <= 1<<sel, idx <= sel, active <= 1.
  - cnt is held at 0; wrap=0.
- Scan mode (mode=1, en=1): two-state FSM, SCAN_DWELL and SCAN_STEP, folded into the cnt compare.
  - Each cycle, if cnt >= dwell: cnt <= 0 and idx <= idx+1 (mod N). Use >= so that lowering dwell mid-step cannot overshoot.
  - Otherwise cnt <= cnt+1.
  - y <= 1<<idx_next, active <= 1.
  - wrap <= 1 for exactly the cycle in which idx becomes 0 after being N-1.
- Entry into scan (mode 0→1 edge, sampled against the previous-mode register):
  - idx <= 0, cnt <= 0, wrap <= 0.
  - Scan always starts at line 0 regardless of sel.
- Exit from scan (mode 1→0): the next edge applies the direct decode of sel. cnt clears.
- en=0:
  - y <= 0, active <= 0, wrap <= 0.
  - idx and cnt hold. Re-enabling in scan mode resumes the interrupted step with the remaining dwell.
- Simultaneous events: rst has priority over everything; en=0 has priority over a mode edge. A mode edge seen while en=0 is acted on at the first enabled cycle.
- Arithmetic: cnt is DWELL_W bits wide, compared unsigned. idx increment wraps naturally in SEL_W bits.
- y is always one-hot or all-zero; it is never multi-hot.

## Timing
- Direct-mode latency: 1 cycle from sel/en to y.
- Scan step period: dwell+1 cycles. dwell=0 advances every cycle. Full sweep = N*(dwell+1) cycles.
- The wrap pulse coincides with the first cycle of y[0] in each sweep after the first. No wrap on scan entry.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- Macro: DECODER_SCAN_EN.
- Defined:
  - Scan mode, the dwell counter and wrap are implemented as described.
- Undefined:
  - The mode and dwell inputs are ignored and the block always operates in direct mode.
  - wrap is tied 0.
  - No counter or previous-mode flops are synthesised.
  - Port list is unchanged.

## Structure
- Shared package decoder_pkg:
  - MODE_DIRECT=1'b0 and MODE_SCAN=1'b1 constants.
  - A function onehot(sel) returning the N-bit vector, for reuse by the bench and the RTL.
- One sub-module: decoder_scan_ctr, containing the cnt/idx/wrap logic, instantiated only under DECODER_SCAN_EN.

## Test plan
Default parameters unless stated.
- Reset and direct decode:
  - Stimulus: rst for 2 cycles, then en=1, mode=0, sel=0,1,2,3 in consecutive cycles.
  - Response: y = 0001, 0010, 0100, 1000, each one cycle after its sel; all outputs 0 during reset.
- Enable:
  - Stimulus: en=0 with sel=2.
  - Response: y=0000 and active=0 next cycle; re-enabling gives y=0100 one cycle later.
- Scan with dwell=0:
  - Stimulus: mode=1, dwell=0.
  - Response: y = 0001, 0010, 0100, 1000, 0001 on successive cycles; wrap high only with the second 0001.
- Scan with dwell=2 and freeze:
  - Stimulus: mode=1, dwell=2; drop en for 5 cycles mid-step.
  - Response: each line holds for 3 enabled cycles; y=0 while en=0; the interrupted step resumes with its remaining count.
- Mode switch and mid-step dwell change:
  - Stimulus 1: switch to direct with sel=3 mid-scan.
  - Response 1: y=1000 next cycle.
  - Stimulus 2: re-enter scan.
  - Response 2: restarts at y=0001.
  - Stimulus 3: lower dwell from 5 to 1 while cnt=4.
  - Response 3: step occurs on the next edge.
- Generalised width and reset priority:
  - Stimulus: SEL_W=3, rst asserted mid-scan.
  - Response: y=0 next edge; exhaustive direct decode of all 8 lines passes.
